// File: rtl/AESDefinitions.sv
// AESDefinitions: shared AES-128 key-schedule types, constants, S-box table and GF(2^8) helpers.
package AESDefinitions;

    typedef logic [127:0] roundKey_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT
    } state_t;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT      = 8'h01;

    // Byte 0 of the S-box sits in the most significant byte of this vector.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/sub_word.sv
// sub_word: AES SubWord, four parallel S-box lookups on a 32-bit word.
module sub_word
    import AESDefinitions::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);

    assign subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/round_key_generator.sv
// round_key_generator: AES-128 key schedule emitting round keys 0..NUM_ROUNDS over a valid/ready handshake.
// Define ROUNDKEY_REVERSE_EN to add a key table and a reverse port for NUM_ROUNDS..0 (decryption) order.
module round_key_generator
    import AESDefinitions::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
`ifdef ROUNDKEY_REVERSE_EN
    input  logic        reverse,
`endif
    input  roundKey_t   cipherKey,
    output logic        keyValid,
    input  logic        keyReady,
    output roundKey_t   roundKey,
    output logic [3:0]  roundIndex,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_INDEX = 4'(NUM_ROUNDS);

    state_t      state;
    logic [7:0]  rcon;
    roundKey_t   exp_src;
    roundKey_t   next_key;
    logic [31:0] sub_rot;
    logic [31:0] w0, w1, w2, w3;
    logic        handshake;
    logic        last_key;

`ifdef ROUNDKEY_REVERSE_EN
    roundKey_t   fill_key;
    logic [3:0]  fill_index;
    logic        rev_mode;
    roundKey_t   key_table [0:NUM_ROUNDS];

    assign exp_src  = (state == FILL) ? fill_key : roundKey;
    assign last_key = rev_mode ? (roundIndex == 4'd0) : (roundIndex == LAST_INDEX);
`else
    assign exp_src  = roundKey;
    assign last_key = (roundIndex == LAST_INDEX);
`endif

    assign handshake = keyValid & keyReady;
    assign busy      = (state != IDLE);

    sub_word u_sub_word (
        .word   ({exp_src[23:0], exp_src[31:24]}),
        .subbed (sub_rot)
    );

    // One FIPS-197 expansion step; w0 is the most significant word of the key.
    assign w0       = exp_src[127:96] ^ sub_rot ^ {rcon, 24'h0};
    assign w1       = exp_src[95:64] ^ w0;
    assign w2       = exp_src[63:32] ^ w1;
    assign w3       = exp_src[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            keyValid   <= 1'b0;
            roundKey   <= '0;
            roundIndex <= '0;
            done       <= 1'b0;
            rcon       <= RCON_INIT;
`ifdef ROUNDKEY_REVERSE_EN
            fill_key   <= '0;
            fill_index <= '0;
            rev_mode   <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_table[i] <= '0;
            end
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rcon <= RCON_INIT;
`ifdef ROUNDKEY_REVERSE_EN
                        rev_mode <= reverse;
                        if (reverse) begin
                            fill_key   <= cipherKey;
                            fill_index <= '0;
                            state      <= FILL;
                        end else begin
                            keyValid   <= 1'b1;
                            roundKey   <= cipherKey;
                            roundIndex <= '0;
                            state      <= EMIT;
                        end
`else
                        keyValid   <= 1'b1;
                        roundKey   <= cipherKey;
                        roundIndex <= '0;
                        state      <= EMIT;
`endif
                    end
                end
`ifdef ROUNDKEY_REVERSE_EN
                // The last key computed is also the first one presented, so it bypasses the table.
                FILL: begin
                    key_table[fill_index] <= fill_key;
                    fill_key              <= next_key;
                    rcon                  <= xtime(rcon);
                    fill_index            <= fill_index + 4'd1;
                    if (fill_index == LAST_INDEX) begin
                        keyValid   <= 1'b1;
                        roundKey   <= fill_key;
                        roundIndex <= LAST_INDEX;
                        state      <= EMIT;
                    end
                end
`endif
                EMIT: begin
                    if (handshake) begin
                        if (last_key) begin
                            keyValid   <= 1'b0;
                            roundKey   <= '0;
                            roundIndex <= '0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end
`ifdef ROUNDKEY_REVERSE_EN
                        else if (rev_mode) begin
                            roundKey   <= key_table[roundIndex - 4'd1];
                            roundIndex <= roundIndex - 4'd1;
                        end
`endif
                        else begin
                            roundKey   <= next_key;
                            rcon       <= xtime(rcon);
                            roundIndex <= roundIndex + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_generator.sv
// tb_round_key_generator: directed bench for round_key_generator with a word-level FIPS-197 reference model.
// Exercises decryption-order emission as well when ROUNDKEY_REVERSE_EN is defined.
module tb_round_key_generator;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY1      = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef ROUNDKEY_REVERSE_EN
    localparam bit REV_BUILD = 1'b1;
`else
    localparam bit REV_BUILD = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         rev_in = 1'b0;
    logic [127:0] cipherKey = '0;
    logic         keyReady = 1'b0;
    logic         keyValid;
    logic [127:0] roundKey;
    logic [3:0]   roundIndex;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail = 0;
    int done_count = 0;
    bit check_en = 1'b0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] fips_sched [0:NR];
    logic [127:0] m_sched [0:NR];
    bit           m_busy = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_done = 1'b0;
    bit           m_rev = 1'b0;
    int           m_pos = 0;
    int           m_fill = 0;

    round_key_generator #(.NUM_ROUNDS(NR)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
`ifdef ROUNDKEY_REVERSE_EN
        .reverse    (rev_in),
`endif
        .cipherKey  (cipherKey),
        .keyValid   (keyValid),
        .keyReady   (keyReady),
        .roundKey   (roundKey),
        .roundIndex (roundIndex),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_round_key(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4 * (r + 1); i++) begin
            temp = w[i - 1];
            if (i % 4 == 0) begin
                temp = {sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]], sbox_m[temp[31:24]]}
                       ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ temp;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting, expected event within bound", name);
    endtask

    // Reference behaviour: where the consumer is in the emission sequence, advanced per accepted transfer.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_rev = 1'b0; m_pos = 0; m_fill = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    for (int r = 0; r <= NR; r++) m_sched[r] = model_round_key(cipherKey, r);
                    m_busy  = 1'b1;
                    m_pos   = 0;
                    m_rev   = REV_BUILD && rev_in;
                    m_fill  = m_rev ? NR + 1 : 0;
                    m_valid = !m_rev;
                end
            end else if (m_fill > 0) begin
                m_fill--;
                if (m_fill == 0) m_valid = 1'b1;
            end else if (m_valid && keyReady) begin
                if (m_pos == NR) begin
                    m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [3:0] exp_idx;
        if (check_en) begin
            exp_idx = 4'(m_rev ? NR - m_pos : m_pos);
            check_output("model_keyValid", keyValid, m_valid);
            check_output("model_roundKey", roundKey, m_valid ? m_sched[exp_idx] : 128'h0);
            check_output("model_roundIndex", roundIndex, m_valid ? exp_idx : 4'h0);
            check_output("model_busy", busy, m_busy);
            check_output("model_done", done, m_done);
        end
        if (done) done_count++;
    end

    task automatic apply_stimulus(input logic [127:0] key, input logic rev);
        @(negedge clock);
        cipherKey = key;
        rev_in    = rev;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic wait_index(input logic [3:0] idx, input string name);
        for (int i = 0; i < 60; i++) begin
            if (keyValid && roundIndex == idx) return;
            @(negedge clock);
        end
        report_timeout(name);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            @(negedge clock);
        end
        report_timeout(name);
    endtask

    initial begin
        int dc0;
        int lat;
        build_sbox();
        for (int r = 0; r <= NR; r++) fips_sched[r] = model_round_key(FIPS_KEY, r);

        check_output("pin_sbox_00", sbox_m[8'h00], 8'h63);
        check_output("pin_sbox_53", sbox_m[8'h53], 8'hed);
        check_output("pin_sbox_ff", sbox_m[8'hff], 8'h16);
        check_output("pin_model_key0", fips_sched[0], FIPS_KEY);
        check_output("pin_model_key1", fips_sched[1], KEY1);
        check_output("pin_model_key10", fips_sched[NR], KEY10);

        #1;
        check_output("reset_keyValid", keyValid, 1'b0);
        check_output("reset_roundKey", roundKey, 128'h0);
        check_output("reset_roundIndex", roundIndex, 4'h0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_done", done, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_en = 1'b1;

        $display("[TB] keyReady toggling while idle");
        dc0 = done_count;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            keyReady = 1'($urandom_range(0, 1));
            check_output("idle_keyValid", keyValid, 1'b0);
            check_output("idle_roundKey", roundKey, 128'h0);
        end
        @(negedge clock);
        check_output("idle_no_done", 32'(done_count - dc0), 32'd0);

        $display("[TB] FIPS-197 schedule, keyReady held high");
        keyReady = 1'b1;
        dc0 = done_count;
        apply_stimulus(FIPS_KEY, 1'b0);
        check_output("latency_keyValid", keyValid, 1'b1);
        check_output("key0", roundKey, FIPS_KEY);
        @(negedge clock);
        check_output("key1", roundKey, KEY1);
        check_output("key1_index", roundIndex, 4'd1);
        wait_index(4'd10, "wait_key10");
        check_output("key10", roundKey, KEY10);
        @(negedge clock);
        check_output("done_after_key10", done, 1'b1);
        check_output("valid_drop_after_key10", keyValid, 1'b0);
        repeat (2) @(negedge clock);
        check_output("done_single_pulse", 32'(done_count - dc0), 32'd1);

        $display("[TB] backpressure at round 3");
        apply_stimulus(FIPS_KEY, 1'b0);
        wait_index(4'd3, "wait_key3");
        keyReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("stall_valid", keyValid, 1'b1);
            check_output("stall_index", roundIndex, 4'd3);
            check_output("stall_key3", roundKey, fips_sched[3]);
        end
        keyReady = 1'b1;
        @(negedge clock);
        check_output("resume_index", roundIndex, 4'd4);
        check_output("resume_key4", roundKey, fips_sched[4]);
        wait_done("done_after_stall");

        $display("[TB] start with new key while busy");
        apply_stimulus(FIPS_KEY, 1'b0);
        wait_index(4'd5, "wait_key5");
        cipherKey = OTHER_KEY;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_index(4'd10, "wait_key10_busy_start");
        check_output("busy_start_key10", roundKey, KEY10);
        wait_done("done_busy_start");

        $display("[TB] reset mid-schedule");
        apply_stimulus(FIPS_KEY, 1'b0);
        wait_index(4'd6, "wait_key6");
        #2 reset = 1'b1;
        #1;
        check_output("abort_keyValid", keyValid, 1'b0);
        check_output("abort_roundKey", roundKey, 128'h0);
        check_output("abort_roundIndex", roundIndex, 4'h0);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("post_abort_idle", keyValid, 1'b0);
        apply_stimulus(FIPS_KEY, 1'b0);
        check_output("restart_key0", roundKey, FIPS_KEY);
        check_output("restart_index0", roundIndex, 4'd0);
        wait_done("done_after_restart");

`ifdef ROUNDKEY_REVERSE_EN
        $display("[TB] reverse-order schedule");
        apply_stimulus(FIPS_KEY, 1'b1);
        rev_in = 1'b0;
        lat = 1;
        while (!keyValid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check_output("reverse_latency", 32'(lat), 32'(NR + 2));
        check_output("reverse_first_key", roundKey, KEY10);
        check_output("reverse_first_index", roundIndex, 4'd10);
        wait_index(4'd0, "wait_reverse_key0");
        check_output("reverse_last_key", roundKey, FIPS_KEY);
        @(negedge clock);
        check_output("reverse_done", done, 1'b1);
`else
        lat = 0;
`endif

        repeat (3) @(negedge clock);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, expected completion before 200000");
        $fatal(1, "[TB] global timeout");
    end

endmodule
